serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_full_sub.sv | 18 +
 rtl/serial_sub.sv | 112 +++++++++++
 tb/tb_serial_sub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// the default operand width used by the top level.
package serial_sub_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed so that other blocks and
  // debug tools see the same values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor: computes a - b - bin for a single bit position
// and produces the difference bit and the borrow into the next position.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of the three inputs.
  assign d    = a ^ b ^ bin;

  // A borrow is needed when b exceeds a outright, or when a and b are equal
  // and a borrow is already pending from the lower bit.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_sub

// File: rtl/serial_sub.sv
// Bit-serial subtractor. A start in IDLE captures a and b, then one bit is
// processed per clock LSB-first through a single full subtractor. The
// result is assembled by shifting difference bits in from the MSB end so
// that after WIDTH shifts the first bit lands in position 0.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // The counter only has to reach WIDTH-1; keep at least one bit so the
  // smallest legal widths still get a real register.
  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_diffBit;
  logic             w_borrowNext;

  // The single shared bit slice always looks at the current LSBs and the
  // running borrow.
  full_sub u_fullSub (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_diffBit),
    .bout (w_borrowNext)
  );

  // Controller and datapath in one block. busy follows the RUN state, while
  // done is raised on the way out of DONE so the pulse lands in the cycle
  // after the DONE state and never overlaps busy. bout is only refreshed on
  // the final bit so it keeps reporting the last completed result while a
  // new operation is still in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_diff   <= {w_diffBit, r_diff[WIDTH-1:1]};
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_borrowNext;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_bout  <= w_borrowNext;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub: an 8-bit instance exercised with
// hand-computed vectors, mid-run start and reset cases, plus a 4-bit
// instance swept over every operand pair with start held high.
module tb_serial_sub;

  logic       clk;
  logic       rst;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;

  int compareCount;
  int mismatchCount;

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one 8-bit subtraction and checks timing, result and the quiet
  // period afterwards. Operands are scrambled right after acceptance to
  // show they were captured; with midStart a second request is pulsed
  // during RUN and must be ignored.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic [7:0] expDiff, input logic expBout,
                               input bit midStart, input string tag);
    int cycles;
    int busyCycles;
    int overlap;
    int extra;
    bit seen;
    @(negedge clk);
    a     = opA;
    b     = opB;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~opA;
    b     = ~opB;
    cycles     = 0;
    busyCycles = 0;
    overlap    = 0;
    seen       = 1'b0;
    while (!seen && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) checkOutput({tag, "/diffClear"}, 32'(diff), 32'h0);
      if (midStart && cycles == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h01;
      end
      if (midStart && cycles == 4) start = 1'b0;
      if (busy) busyCycles++;
      if (busy && done) overlap++;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "/latency"}, 32'(cycles - 1), 32'd9);
    checkOutput({tag, "/busyCycles"}, 32'(busyCycles), 32'd8);
    checkOutput({tag, "/overlap"}, 32'(overlap), 32'd0);
    checkOutput({tag, "/diff"}, 32'(diff), 32'(expDiff));
    checkOutput({tag, "/bout"}, 32'(bout), 32'(expBout));
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checkOutput({tag, "/quiet"}, 32'(extra), 32'd0);
    checkOutput({tag, "/diffHold"}, 32'(diff), 32'(expDiff));
    checkOutput({tag, "/boutHold"}, 32'(bout), 32'(expBout));
  endtask

  // Main sequence: reset, directed vectors, mid-run reset, 4-bit sweep.
  initial begin
    int extra;
    int cycles;
    logic [7:0] nextPair;
    logic [3:0] expA;
    logic [3:0] expB;
    logic [3:0] expDiff4;

    compareCount  = 0;
    mismatchCount = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    start4 = 1'b0;
    a4     = 4'h0;
    b4     = 4'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset/busy", 32'(busy), 32'd0);
    checkOutput("reset/done", 32'(done), 32'd0);
    checkOutput("reset/diff", 32'(diff), 32'd0);
    checkOutput("reset/bout", 32'(bout), 32'd0);
    checkOutput("reset/busy4", 32'(busy4), 32'd0);
    rst = 1'b0;

    applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub5m3");
    applyStimulus(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub3m5");
    applyStimulus(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "sub00mFF");

    // Reset during bit 4: bits 0..3 of FF-00 are in diff[7:4] by then.
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rstRun/partial", 32'(diff), 32'hF0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstRun/busy", 32'(busy), 32'd0);
    checkOutput("rstRun/done", 32'(done), 32'd0);
    checkOutput("rstRun/diff", 32'(diff), 32'd0);
    checkOutput("rstRun/bout", 32'(bout), 32'd0);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checkOutput("rstRun/noDone", 32'(extra), 32'd0);
    applyStimulus(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "sub9m4");

    applyStimulus(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, "subA5mA5");
    applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, "subFFm00");
    applyStimulus(8'h40, 8'h10, 8'h30, 1'b0, 1'b1, "midStart");

    // Exhaustive 4-bit sweep with start held high; the first start is
    // accepted on the first edge after reset drops.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    a4     = 4'h0;
    b4     = 4'h0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) begin
      expA     = 4'(k >> 4);
      expB     = 4'(k);
      expDiff4 = expA - expB;
      if (k < 255) begin
        nextPair = 8'(k + 1);
        a4 = nextPair[7:4];
        b4 = nextPair[3:0];
      end else begin
        start4 = 1'b0;
      end
      cycles = 0;
      do begin
        @(negedge clk);
        cycles++;
      end while (!done4 && cycles < 20);
      checkOutput("sweep/latency", 32'(cycles - 1), 32'd5);
      checkOutput("sweep/diff", 32'(diff4), 32'(expDiff4));
      checkOutput("sweep/bout", 32'(bout4), 32'(expA < expB));
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule : tb_serial_sub
